// File: rtl/nand_op_sched.sv
`timescale 1ns/1ps
// Round-robin operation scheduler in front of the NAND byte-cycle engine: expands
// READ/PROG/ERAS/RSET requests into command/address bytes, waits on F_nRB, reports status.
module nand_op_sched #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
   parameter logic [3:0]  NRB_LOW_WIN    = 4'd8
) (
   input  logic        P_clk,
   input  logic        P_nrst,
   input  logic        R0_Valid,
   input  logic        R1_Valid,
   input  logic [1:0]  R0_Op,
   input  logic [1:0]  R1_Op,
   input  logic [39:0] R0_Addr,
   input  logic [39:0] R1_Addr,
   input  logic [7:0]  R0_Length,
   input  logic [7:0]  R1_Length,
   output logic        R0_Ready,
   output logic        R1_Ready,
   output logic [7:0]  C_Cmd,
   output logic [7:0]  C_Addr,
   output logic [7:0]  C_Length,
   output logic        S_Valid,
   output logic        S_Kind,
   input  logic        S_Ready,
   input  logic        F_nRB,
   input  logic [7:0]  C_Status,
   input  logic        C_StatusValid,
   output logic        Done,
   output logic        Done_Id,
   output logic [1:0]  Done_Err
);
   typedef enum logic [3:0] {
      IDLE, GRANT, CMD1, ADDR, CMD2, WAIT_LO, WAIT_HI, STAT_CMD, STAT_RD, DONE
   } state_t;

   localparam logic [1:0] OP_READ = 2'b00;
   localparam logic [1:0] OP_PROG = 2'b01;
   localparam logic [1:0] OP_ERAS = 2'b10;
   localparam logic [1:0] OP_RSET = 2'b11;

   state_t      state_q, state_d;
   logic        win_q, win_d;
   logic        id_q, id_d;
   logic        last_q, last_d;
   logic [1:0]  op_q, op_d;
   logic [1:0]  err_q, err_d;
   logic [39:0] addr_q, addr_d;
   logic [7:0]  len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bidx_q, bidx_d;
   logic        nrb_meta_q, nrb_q;
   logic [2:0]  abyte;
   logic [2:0]  alast;
   logic        unused_status;

   // F_nRB is asynchronous to P_clk; idle level is "ready"
   always_ff @(posedge P_clk or negedge P_nrst) begin
      if (!P_nrst) begin
         nrb_meta_q <= 1'b1;
         nrb_q      <= 1'b1;
      end else begin
         nrb_meta_q <= F_nRB;
         nrb_q      <= nrb_meta_q;
      end
   end

   always_ff @(posedge P_clk or negedge P_nrst) begin
      if (!P_nrst) begin
         state_q <= IDLE;
         win_q   <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         op_q    <= 2'b00;
         err_q   <= 2'b00;
         addr_q  <= 40'd0;
         len_q   <= 8'd0;
         cnt_q   <= 16'd0;
         bidx_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         id_q    <= id_d;
         last_q  <= last_d;
         op_q    <= op_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         bidx_q  <= bidx_d;
      end
   end

   // Erase sends only the three row bytes, so its counter is offset onto Addr[23:16]
   assign abyte         = (op_q == OP_ERAS) ? bidx_q + 3'd2 : bidx_q;
   assign alast         = (op_q == OP_ERAS) ? 3'd2 : 3'd4;
   assign C_Length      = len_q;
   assign unused_status = ^C_Status[7:1];

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      id_d     = id_q;
      last_d   = last_q;
      op_d     = op_q;
      err_d    = err_q;
      addr_d   = addr_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      bidx_d   = bidx_q;
      R0_Ready = 1'b0;
      R1_Ready = 1'b0;
      C_Cmd    = 8'h00;
      C_Addr   = 8'h00;
      S_Valid  = 1'b0;
      S_Kind   = 1'b0;
      Done     = 1'b0;
      Done_Id  = 1'b0;
      Done_Err = 2'b00;
      case (state_q)
         IDLE: begin
            if (R0_Valid || R1_Valid) begin
               win_d   = (R0_Valid && R1_Valid) ? ~last_q : R1_Valid;
               state_d = GRANT;
            end
         end
         GRANT: begin
            R0_Ready = ~win_q;
            R1_Ready = win_q;
            id_d     = win_q;
            op_d     = win_q ? R1_Op : R0_Op;
            addr_d   = win_q ? R1_Addr : R0_Addr;
            len_d    = win_q ? R1_Length : R0_Length;
            err_d    = 2'b00;
            state_d  = CMD1;
         end
         CMD1: begin
            S_Valid = 1'b1;
            case (op_q)
               OP_READ: C_Cmd = 8'h00;
               OP_PROG: C_Cmd = 8'h80;
               OP_ERAS: C_Cmd = 8'h60;
               default: C_Cmd = 8'hFF;
            endcase
            if (S_Ready) begin
               cnt_d   = 16'd0;
               bidx_d  = 3'd0;
               state_d = (op_q == OP_RSET) ? WAIT_LO : ADDR;
            end
         end
         ADDR: begin
            S_Valid = 1'b1;
            S_Kind  = 1'b1;
            case (abyte)
               3'd0:    C_Addr = addr_q[7:0];
               3'd1:    C_Addr = addr_q[15:8];
               3'd2:    C_Addr = addr_q[23:16];
               3'd3:    C_Addr = addr_q[31:24];
               default: C_Addr = addr_q[39:32];
            endcase
            if (S_Ready) begin
               if (bidx_q == alast) state_d = CMD2;
               else                 bidx_d  = bidx_q + 3'd1;
            end
         end
         CMD2: begin
            S_Valid = 1'b1;
            case (op_q)
               OP_PROG: C_Cmd = 8'h10;
               OP_ERAS: C_Cmd = 8'hD0;
               default: C_Cmd = 8'h30;
            endcase
            if (S_Ready) begin
               cnt_d   = 16'd0;
               state_d = WAIT_LO;
            end
         end
         WAIT_LO: begin
            // A busy pulse that never shows up means the array finished before we looked
            if (!nrb_q || cnt_q == {12'd0, NRB_LOW_WIN} - 16'd1) begin
               cnt_d   = 16'd0;
               state_d = WAIT_HI;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         WAIT_HI: begin
            if (nrb_q) begin
               state_d = (op_q == OP_PROG || op_q == OP_ERAS) ? STAT_CMD : DONE;
            end else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
               err_d   = 2'b10;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STAT_CMD: begin
            S_Valid = 1'b1;
            C_Cmd   = 8'h70;
            if (S_Ready) state_d = STAT_RD;
         end
         STAT_RD: begin
            if (C_StatusValid) begin
               err_d   = {1'b0, C_Status[0]};
               state_d = DONE;
            end
         end
         DONE: begin
            Done     = 1'b1;
            Done_Id  = id_q;
            Done_Err = err_q;
            last_d   = id_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_nand_op_sched.sv
`timescale 1ns/1ps
// Randomized bench for nand_op_sched: an interval-arithmetic flash/arbiter model predicts
// byte order, grant winner, Done cycle and Done_Err for every operation.
module tb_nand_op_sched;
   localparam int T = 100;
   localparam int W = 8;

   logic        P_clk = 1'b0;
   logic        P_nrst;
   logic        R0_Valid, R1_Valid;
   logic [1:0]  R0_Op, R1_Op;
   logic [39:0] R0_Addr, R1_Addr;
   logic [7:0]  R0_Length, R1_Length;
   logic        R0_Ready, R1_Ready;
   logic [7:0]  C_Cmd, C_Addr, C_Length;
   logic        S_Valid, S_Kind, S_Ready, F_nRB;
   logic [7:0]  C_Status;
   logic        C_StatusValid;
   logic        Done, Done_Id;
   logic [1:0]  Done_Err;

   nand_op_sched #(.TIMEOUT_CYCLES(16'd100), .NRB_LOW_WIN(4'd8)) dut (
      .P_clk(P_clk), .P_nrst(P_nrst),
      .R0_Valid(R0_Valid), .R1_Valid(R1_Valid), .R0_Op(R0_Op), .R1_Op(R1_Op),
      .R0_Addr(R0_Addr), .R1_Addr(R1_Addr), .R0_Length(R0_Length), .R1_Length(R1_Length),
      .R0_Ready(R0_Ready), .R1_Ready(R1_Ready),
      .C_Cmd(C_Cmd), .C_Addr(C_Addr), .C_Length(C_Length),
      .S_Valid(S_Valid), .S_Kind(S_Kind), .S_Ready(S_Ready),
      .F_nRB(F_nRB), .C_Status(C_Status), .C_StatusValid(C_StatusValid),
      .Done(Done), .Done_Id(Done_Id), .Done_Err(Done_Err)
   );

   always #5 P_clk = ~P_clk;

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc     = 0;
   int last_id = 1;
   int op_no   = 0;
   logic [8:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge P_clk);
      cyc++;
   endtask

   task automatic build_seq(input logic [1:0] op, input logic [39:0] ad);
      logic [39:0] sh;
      exp_q.delete();
      case (op)
         2'b00:   exp_q.push_back({1'b0, 8'h00});
         2'b01:   exp_q.push_back({1'b0, 8'h80});
         2'b10:   exp_q.push_back({1'b0, 8'h60});
         default: exp_q.push_back({1'b0, 8'hFF});
      endcase
      if (op != 2'b11) begin
         for (int k = (op == 2'b10) ? 2 : 0; k < 5; k++) begin
            sh = ad >> (8 * k);
            exp_q.push_back({1'b1, sh[7:0]});
         end
         case (op)
            2'b00:   exp_q.push_back({1'b0, 8'h30});
            2'b01:   exp_q.push_back({1'b0, 8'h10});
            default: exp_q.push_back({1'b0, 8'hD0});
         endcase
      end
   endtask

   // d/L: flash pulls F_nRB low d cycles after the final command byte, for L cycles (0 = never)
   task automatic run_op(input bit v0, input bit v1, input logic [1:0] op0, input logic [1:0] op1,
                         input logic [39:0] ad0, input logic [39:0] ad1,
                         input logic [7:0] ln0, input logic [7:0] ln1,
                         input int d, input int L, input int sdel, input logic [7:0] status,
                         input int sr_pct);
      int win, c0, a, acc70, sv, done_c, exp_done, nxt, first_stat, lo_s, lo_e, h0, e;
      bit tmo, stat_op;
      logic [1:0] op, exp_err;
      logic [39:0] ad;
      logic [7:0] ln;
      logic [8:0] b;
      win     = (v0 && v1) ? 1 - last_id : (v1 ? 1 : 0);
      op      = win ? op1 : op0;
      ad      = win ? ad1 : ad0;
      ln      = win ? ln1 : ln0;
      stat_op = (op == 2'b01) || (op == 2'b10);
      build_seq(op, ad);
      a = -1; acc70 = -1; sv = -1; done_c = -1; exp_done = -1; nxt = -1; first_stat = -1;
      tmo = 1'b0;
      exp_err = 2'b00;
      step();
      R0_Valid = v0; R1_Valid = v1; R0_Op = op0; R1_Op = op1;
      R0_Addr = ad0; R1_Addr = ad1; R0_Length = ln0; R1_Length = ln1;
      S_Ready = 1'b0; C_StatusValid = 1'b0; F_nRB = 1'b1;
      c0 = cyc;
      for (int n = 0; n < 3000 && done_c < 0; n++) begin
         step();
         chk("ready", {R1_Ready, R0_Ready}, (cyc == c0 + 1) ? (win ? 2'b10 : 2'b01) : 2'b00);
         if (cyc == c0 + 2) begin
            chk("cmd1_offer", S_Valid, 1'b1);
            R0_Valid = 1'b0; R1_Valid = 1'b0;
            R0_Op = 2'($urandom); R1_Op = 2'($urandom);
            R0_Addr = {8'($urandom), $urandom}; R1_Addr = {8'($urandom), $urandom};
            R0_Length = 8'($urandom); R1_Length = 8'($urandom);
         end
         if (a >= 0 && first_stat < 0 && S_Valid) first_stat = cyc;
         if (Done) begin
            done_c  = cyc;
            exp_err = tmo ? 2'b10 : (stat_op ? {1'b0, status[0]} : 2'b00);
            chk("done_cycle", done_c, exp_done);
            chk("done_id", Done_Id, win);
            chk("done_err", Done_Err, exp_err);
            chk("length", C_Length, ln);
            chk("seq_left", exp_q.size(), 0);
            if (stat_op && !tmo) chk("stat_cmd_cycle", first_stat, nxt);
         end else begin
            S_Ready = ($urandom_range(99) < sr_pct);
            if (S_Valid && S_Ready) begin
               if (exp_q.size() == 0) begin
                  chk("extra_byte", S_Valid, 1'b0);
               end else begin
                  b = exp_q.pop_front();
                  chk("byte", {S_Kind, S_Kind ? C_Addr : C_Cmd}, b);
                  if (a >= 0 && acc70 < 0) begin
                     acc70    = cyc;
                     sv       = cyc + sdel;
                     exp_done = sv + 1;
                  end else if (exp_q.size() == 0 && a < 0) begin
                     a    = cyc;
                     lo_s = a + d + 2;
                     lo_e = a + d + L + 2;
                     h0   = (L > 0 && lo_s <= a + W) ? lo_s + 1 : a + W + 1;
                     e    = (L > 0 && h0 >= lo_s && h0 < lo_e) ? lo_e : h0;
                     if (e - h0 >= T) begin
                        tmo      = 1'b1;
                        exp_done = h0 + T;
                     end else if (stat_op) begin
                        nxt = e + 1;
                        exp_q.push_back({1'b0, 8'h70});
                     end else begin
                        exp_done = e + 1;
                     end
                  end
               end
            end
            F_nRB         = !(a >= 0 && L > 0 && cyc >= a + d && cyc < a + d + L);
            C_StatusValid = (sv >= 0 && cyc == sv);
            C_Status      = C_StatusValid ? status : 8'($urandom);
         end
      end
      if (done_c < 0) chk("done_seen", Done, 1'b1);
      last_id = win;
      op_no++;
      $display("op %0d: id=%0d op=%0d addr=%010h len=%0d err=%0d done@%0d", op_no, win, op,
               ad, ln, Done_Err, done_c);
      step();
      chk("done_pulse", Done, 1'b0);
      S_Ready = 1'b0; C_StatusValid = 1'b0;
      F_nRB = !(a >= 0 && L > 0 && cyc >= a + d && cyc < a + d + L);
      for (int n = 0; n < 400 && a >= 0 && L > 0 && cyc < a + d + L; n++) begin
         step();
         F_nRB = !(cyc < a + d + L);
      end
      F_nRB = 1'b1;
   endtask

   task automatic reset_mid_addr();
      int n_addr;
      bit hit;
      n_addr = 0;
      hit    = 1'b0;
      step();
      R0_Valid = 1'b1; R0_Op = 2'b00; R0_Addr = 40'h12_3456_789A; R0_Length = 8'd4;
      S_Ready = 1'b1; F_nRB = 1'b1;
      for (int n = 0; n < 40 && !hit; n++) begin
         step();
         if (S_Valid && S_Kind) begin
            if (n_addr == 3) hit = 1'b1;
            else n_addr++;
         end
      end
      chk("rst_reach_addr3", hit, 1'b1);
      P_nrst = 1'b0;
      R0_Valid = 1'b0;
      #1;
      chk("rst_svalid", S_Valid, 1'b0);
      chk("rst_caddr", C_Addr, 8'h00);
      chk("rst_clen", C_Length, 8'h00);
      for (int n = 0; n < 3; n++) begin
         step();
         chk("rst_hold", {Done, S_Valid, R0_Ready, R1_Ready}, 4'b0000);
      end
      P_nrst  = 1'b1;
      last_id = 1;
   endtask

   initial begin
      int r, L;
      P_nrst = 1'b0;
      R0_Valid = 1'b0; R1_Valid = 1'b0; R0_Op = 2'b00; R1_Op = 2'b00;
      R0_Addr = 40'd0; R1_Addr = 40'd0; R0_Length = 8'd0; R1_Length = 8'd0;
      S_Ready = 1'b0; F_nRB = 1'b1; C_Status = 8'h00; C_StatusValid = 1'b0;
      repeat (3) step();
      chk("reset_outputs", {R0_Ready, R1_Ready, S_Valid, S_Kind, Done, Done_Id, Done_Err,
                            C_Cmd, C_Addr, C_Length}, 32'd0);
      P_nrst = 1'b1;
      // Directed scenarios
      run_op(1, 0, 2'b00, 2'b00, 40'h00_0012_3400, 40'd0, 8'd8, 8'd0, 1, 20, 1, 8'h00, 100);
      reset_mid_addr();
      for (int i = 0; i < 4; i++)
         run_op(1, 1, 2'($urandom), 2'($urandom), {8'($urandom), $urandom},
                {8'($urandom), $urandom}, 8'($urandom), 8'($urandom),
                $urandom_range(6), $urandom_range(25, 1), $urandom_range(4, 1),
                8'($urandom), 100);
      run_op(0, 1, 2'b00, 2'b10, 40'd0, {24'hABCDEF, 16'h1234}, 8'd0, 8'd0, 2, 15, 3, 8'h01, 100);
      run_op(1, 0, 2'b01, 2'b00, 40'hCA_FE00_1122, 40'd0, 8'd16, 8'd0, 2, 300, 1, 8'h00, 100);
      run_op(0, 1, 2'b00, 2'b11, 40'd0, 40'd0, 8'd0, 8'd0, 0, 0, 1, 8'h00, 100);
      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(19);
         L = (r == 0) ? 0 : ((r == 1) ? 150 : $urandom_range(30, 1));
         r = $urandom_range(2);
         run_op(r != 1, r != 0, 2'($urandom), 2'($urandom), {8'($urandom), $urandom},
                {8'($urandom), $urandom}, 8'($urandom), 8'($urandom),
                $urandom_range(10), L, $urandom_range(5, 1), 8'($urandom),
                $urandom_range(100, 50));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
